// File: rtl/dds_multich_core.sv
// dds_multich_core
//   Multi-channel direct digital synthesis core. Each channel runs a phase
//   accumulator with a runtime tuning word and adds a phase offset. It then
//   produces a saw, triangle, square (with duty) or external-LUT waveform and
//   scales it by an amplitude factor before it reaches the DAC pins.
//
// Ports
//   clk_i        sample clock (only clock)
//   rstn_i       asynchronous active-low reset
//   cfg_we_i     configuration write strobe
//   cfg_ch_i     target channel (indices >= CHANNELS are ignored)
//   cfg_reg_i    0 FTW, 1 POFF, 2 CTRL {duty[31:16], en[2], mode[1:0]}, 3 AMP[15:0]
//   cfg_data_i   write data
//   cfg_ack_o    one-cycle pulse the cycle after every write strobe
//   sync_i       clears every accumulator in the same cycle
//   lut_addr_o   per-channel external ROM address (registered)
//   lut_data_i   per-channel ROM data, one cycle after lut_addr_o
//   dac_data_o   per-channel offset-binary samples, channel k at [k*OUT_W +: OUT_W]
//   dac_valid_o  per-channel sample valid
//   wrap_o       per-channel accumulator carry-out pulse
module dds_multich_core #(
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 32,
  parameter int OUT_W    = 14,
  parameter int LUT_AW   = 10
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       cfg_we_i,
  input  logic [2:0]                 cfg_ch_i,
  input  logic [1:0]                 cfg_reg_i,
  input  logic [31:0]                cfg_data_i,
  output logic                       cfg_ack_o,
  input  logic                       sync_i,
  output logic [CHANNELS*LUT_AW-1:0] lut_addr_o,
  input  logic [CHANNELS*OUT_W-1:0]  lut_data_i,
  output logic [CHANNELS*OUT_W-1:0]  dac_data_o,
  output logic [CHANNELS-1:0]        dac_valid_o,
  output logic [CHANNELS-1:0]        wrap_o
);

  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

  // Configuration registers
  logic [ACC_W-1:0] ftw_q  [CHANNELS];
  logic [ACC_W-1:0] ftw_d  [CHANNELS];
  logic [ACC_W-1:0] poff_q [CHANNELS];
  logic [ACC_W-1:0] poff_d [CHANNELS];
  logic [15:0]      duty_q [CHANNELS];
  logic [15:0]      duty_d [CHANNELS];
  logic [15:0]      amp_q  [CHANNELS];
  logic [15:0]      amp_d  [CHANNELS];
  logic [1:0]       mode_q [CHANNELS];
  logic [1:0]       mode_d [CHANNELS];
  logic [CHANNELS-1:0] en_q, en_d;
  logic cfg_ack_q, cfg_ack_d;

  // S0 accumulator plus the control that travels with it
  logic [ACC_W:0]   sum_c     [CHANNELS];
  logic [ACC_W-1:0] acc_q     [CHANNELS];
  logic [ACC_W-1:0] acc_d     [CHANNELS];
  logic [1:0]       mode_p0_q [CHANNELS];
  logic [1:0]       mode_p0_d [CHANNELS];
  logic [15:0]      duty_p0_q [CHANNELS];
  logic [15:0]      duty_p0_d [CHANNELS];
  logic [15:0]      amp_p0_q  [CHANNELS];
  logic [15:0]      amp_p0_d  [CHANNELS];
  logic [CHANNELS-1:0] wrap_q, wrap_d, vld_p0_q, vld_p0_d;

  // S1 phase
  logic [ACC_W-1:0]  ph_p1_q    [CHANNELS];
  logic [ACC_W-1:0]  ph_p1_d    [CHANNELS];
  logic [LUT_AW-1:0] lut_addr_q [CHANNELS];
  logic [LUT_AW-1:0] lut_addr_d [CHANNELS];
  logic [1:0]        mode_p1_q  [CHANNELS];
  logic [1:0]        mode_p1_d  [CHANNELS];
  logic [15:0]       duty_p1_q  [CHANNELS];
  logic [15:0]       duty_p1_d  [CHANNELS];
  logic [15:0]       amp_p1_q   [CHANNELS];
  logic [15:0]       amp_p1_d   [CHANNELS];
  logic [CHANNELS-1:0] vld_p1_q, vld_p1_d;

  // S2 internal waveform
  logic [OUT_W-1:0] wave_p2_q [CHANNELS];
  logic [OUT_W-1:0] wave_p2_d [CHANNELS];
  logic [1:0]       mode_p2_q [CHANNELS];
  logic [1:0]       mode_p2_d [CHANNELS];
  logic [15:0]      amp_p2_q  [CHANNELS];
  logic [15:0]      amp_p2_d  [CHANNELS];
  logic [CHANNELS-1:0] vld_p2_q, vld_p2_d;

  // S3 selected sample
  logic [OUT_W-1:0] smp_p3_q [CHANNELS];
  logic [OUT_W-1:0] smp_p3_d [CHANNELS];
  logic [15:0]      amp_p3_q [CHANNELS];
  logic [15:0]      amp_p3_d [CHANNELS];
  logic [CHANNELS-1:0] vld_p3_q, vld_p3_d;

  // S4 DAC output
  logic [OUT_W-1:0] dac_q [CHANNELS];
  logic [OUT_W-1:0] dac_d [CHANNELS];
  logic [CHANNELS-1:0] dac_valid_q, dac_valid_d;

  function automatic logic [OUT_W-1:0] wave_gen(input logic [1:0]       mode,
                                                input logic [ACC_W-1:0] ph,
                                                input logic [15:0]      duty);
    logic [OUT_W-1:0] t;
    logic [15:0]      ph16;
    t    = ph[ACC_W-2 -: OUT_W];
    ph16 = ph[ACC_W-1 -: 16];
    case (mode)
      2'd1:    wave_gen = ph[ACC_W-1] ? ~t : t;
      2'd2:    wave_gen = (ph16 < duty) ? '1 : '0;
      default: wave_gen = ph[ACC_W-1 -: OUT_W];
    endcase
  endfunction

  // Scale around midscale: mid + floor((wave - mid) * min(amp, 0x8000) / 2^15).
  // With the factor capped at 1.0 the result always stays inside OUT_W bits.
  function automatic logic [OUT_W-1:0] amp_scale(input logic [OUT_W-1:0] wave,
                                                 input logic [15:0]      amp);
    logic [15:0]               a;
    logic signed [OUT_W:0]     s;
    logic signed [OUT_W+17:0]  s_ext;
    logic signed [OUT_W+17:0]  a_ext;
    logic signed [OUT_W+17:0]  prod;
    a     = (amp > 16'h8000) ? 16'h8000 : amp;
    s     = {1'b0, wave} - {1'b0, MID};
    s_ext = (OUT_W+18)'(s);
    a_ext = (OUT_W+18)'(a);
    prod  = s_ext * a_ext;
    amp_scale = prod[OUT_W+14:15] + MID;
  endfunction

  // Configuration writes
  always_comb begin
    cfg_ack_d = cfg_we_i;
    en_d      = en_q;
    for (int k = 0; k < CHANNELS; k++) begin
      ftw_d[k]  = ftw_q[k];
      poff_d[k] = poff_q[k];
      duty_d[k] = duty_q[k];
      amp_d[k]  = amp_q[k];
      mode_d[k] = mode_q[k];
      if (cfg_we_i && (cfg_ch_i == 3'(k))) begin
        case (cfg_reg_i)
          2'd0: ftw_d[k]  = cfg_data_i[ACC_W-1:0];
          2'd1: poff_d[k] = cfg_data_i[ACC_W-1:0];
          2'd2: begin
            duty_d[k] = cfg_data_i[31:16];
            en_d[k]   = cfg_data_i[2];
            mode_d[k] = cfg_data_i[1:0];
          end
          default: amp_d[k] = cfg_data_i[15:0];
        endcase
      end
    end
  end

  // S0: accumulate; control is snapshotted with the phase it belongs to
  always_comb begin
    vld_p0_d = en_q;
    wrap_d   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sum_c[k]     = {1'b0, acc_q[k]} + {1'b0, ftw_q[k]};
      acc_d[k]     = '0;
      mode_p0_d[k] = mode_q[k];
      duty_p0_d[k] = duty_q[k];
      amp_p0_d[k]  = amp_q[k];
      if (en_q[k] && !sync_i) begin
        acc_d[k]  = sum_c[k][ACC_W-1:0];
        wrap_d[k] = sum_c[k][ACC_W];
      end
    end
  end

  // S1: phase offset and ROM address
  always_comb begin
    vld_p1_d = vld_p0_q;
    for (int k = 0; k < CHANNELS; k++) begin
      ph_p1_d[k]    = acc_q[k] + poff_q[k];
      lut_addr_d[k] = ph_p1_d[k][ACC_W-1 -: LUT_AW];
      mode_p1_d[k]  = mode_p0_q[k];
      duty_p1_d[k]  = duty_p0_q[k];
      amp_p1_d[k]   = amp_p0_q[k];
    end
  end

  // S2: internal waveform (the ROM is fetching in parallel)
  // S3: mode mux between internal waveform and ROM data
  // S4: amplitude scaling, midscale while not valid
  always_comb begin
    vld_p2_d    = vld_p1_q;
    vld_p3_d    = vld_p2_q;
    dac_valid_d = vld_p3_q;
    for (int k = 0; k < CHANNELS; k++) begin
      wave_p2_d[k] = wave_gen(mode_p1_q[k], ph_p1_q[k], duty_p1_q[k]);
      mode_p2_d[k] = mode_p1_q[k];
      amp_p2_d[k]  = amp_p1_q[k];
      smp_p3_d[k]  = (mode_p2_q[k] == 2'd3) ? lut_data_i[k*OUT_W +: OUT_W] : wave_p2_q[k];
      amp_p3_d[k]  = amp_p2_q[k];
      dac_d[k]     = vld_p3_q[k] ? amp_scale(smp_p3_q[k], amp_p3_q[k]) : MID;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cfg_ack_q   <= 1'b0;
      en_q        <= '0;
      wrap_q      <= '0;
      vld_p0_q    <= '0;
      vld_p1_q    <= '0;
      vld_p2_q    <= '0;
      vld_p3_q    <= '0;
      dac_valid_q <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        ftw_q[k]      <= '0;
        poff_q[k]     <= '0;
        duty_q[k]     <= '0;
        amp_q[k]      <= 16'h8000;
        mode_q[k]     <= '0;
        acc_q[k]      <= '0;
        lut_addr_q[k] <= '0;
        dac_q[k]      <= MID;
      end
    end else begin
      cfg_ack_q   <= cfg_ack_d;
      en_q        <= en_d;
      wrap_q      <= wrap_d;
      vld_p0_q    <= vld_p0_d;
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      vld_p3_q    <= vld_p3_d;
      dac_valid_q <= dac_valid_d;
      ftw_q       <= ftw_d;
      poff_q      <= poff_d;
      duty_q      <= duty_d;
      amp_q       <= amp_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      lut_addr_q  <= lut_addr_d;
      dac_q       <= dac_d;
    end
  end

  // Datapath payload; qualified by the vld chain so it needs no reset
  always_ff @(posedge clk_i) begin
    mode_p0_q <= mode_p0_d;
    duty_p0_q <= duty_p0_d;
    amp_p0_q  <= amp_p0_d;
    ph_p1_q   <= ph_p1_d;
    mode_p1_q <= mode_p1_d;
    duty_p1_q <= duty_p1_d;
    amp_p1_q  <= amp_p1_d;
    wave_p2_q <= wave_p2_d;
    mode_p2_q <= mode_p2_d;
    amp_p2_q  <= amp_p2_d;
    smp_p3_q  <= smp_p3_d;
    amp_p3_q  <= amp_p3_d;
  end

  always_comb begin
    lut_addr_o = '0;
    dac_data_o = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      lut_addr_o[k*LUT_AW +: LUT_AW] = lut_addr_q[k];
      dac_data_o[k*OUT_W +: OUT_W]   = dac_q[k];
    end
  end

  assign cfg_ack_o   = cfg_ack_q;
  assign dac_valid_o = dac_valid_q;
  assign wrap_o      = wrap_q;

endmodule
